// File: rtl/key_schedule_seq.sv
// Iterative AES-128 key expansion: one round key per pulse, rounds 0..10,
// using a single time-multiplexed byte S-box and a RoundConst stage.

module RoundConst (
    input  logic [3:0] round,
    input  logic [7:0] S0_in,
    input  logic [7:0] S1_in,
    input  logic [7:0] S2_in,
    input  logic [7:0] S3_in,
    output logic [7:0] D0_out,
    output logic [7:0] D1_out,
    output logic [7:0] D2_out,
    output logic [7:0] D3_out
);
    logic [7:0] rcon;

    always_comb begin
        case (round)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign D0_out = S0_in ^ rcon;
    assign D1_out = S1_in;
    assign D2_out = S2_in;
    assign D3_out = S3_in;
endmodule

module key_schedule_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    output logic [3:0]   rk_round,
    output logic [127:0] rk_out,
    output logic         done
);
    // Entry i of the S-box lives at bits [2047-8i -: 8].
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, LOAD, SUB, UPD} state_t;

    state_t      state, next_state;
    logic [31:0] w0, w1, w2, w3;
    logic [7:0]  t0, t1, t2, t3;
    logic [1:0]  byte_idx;
    logic [3:0]  round;
    logic [7:0]  sbox_in, sbox_out;
    logic [7:0]  d0, d1, d2, d3;
    logic [31:0] w0_n, w1_n, w2_n, w3_n;

    // RotWord byte order: w3 rotated left by one byte.
    always_comb begin
        case (byte_idx)
            2'd0:    sbox_in = w3[23:16];
            2'd1:    sbox_in = w3[15:8];
            2'd2:    sbox_in = w3[7:0];
            default: sbox_in = w3[31:24];
        endcase
    end

    assign sbox_out = SBOX[{~sbox_in, 3'b111} -: 8];

    // The last substituted byte bypasses t3 so the new round key can be
    // registered on the edge that enters UPD and be visible during UPD.
    RoundConst u_rcon (
        .round  (round),
        .S0_in  (t0),
        .S1_in  (t1),
        .S2_in  (t2),
        .S3_in  ((state == SUB) ? sbox_out : t3),
        .D0_out (d0),
        .D1_out (d1),
        .D2_out (d2),
        .D3_out (d3)
    );

    assign w0_n = w0 ^ {d0, d1, d2, d3};
    assign w1_n = w1 ^ w0_n;
    assign w2_n = w2 ^ w1_n;
    assign w3_n = w3 ^ w2_n;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LOAD;
            LOAD:    next_state = SUB;
            SUB:     if (byte_idx == 2'd3) next_state = UPD;
            UPD:     next_state = (round == 4'd10) ? IDLE : SUB;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {w0, w1, w2, w3} <= '0;
            {t0, t1, t2, t3} <= '0;
            byte_idx <= '0;
            round    <= '0;
            busy     <= 1'b0;
            rk_valid <= 1'b0;
            rk_round <= '0;
            rk_out   <= '0;
            done     <= 1'b0;
        end else begin
            rk_valid <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    {w0, w1, w2, w3} <= key_in;
                    round    <= 4'd0;
                    busy     <= 1'b1;
                    rk_valid <= 1'b1;
                    rk_round <= 4'd0;
                    rk_out   <= key_in;
                end
                LOAD: begin
                    round    <= 4'd1;
                    byte_idx <= 2'd0;
                end
                SUB: begin
                    case (byte_idx)
                        2'd0:    t0 <= sbox_out;
                        2'd1:    t1 <= sbox_out;
                        2'd2:    t2 <= sbox_out;
                        default: t3 <= sbox_out;
                    endcase
                    byte_idx <= byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        {w0, w1, w2, w3} <= {w0_n, w1_n, w2_n, w3_n};
                        rk_out   <= {w0_n, w1_n, w2_n, w3_n};
                        rk_round <= round;
                        rk_valid <= 1'b1;
                        done     <= (round == 4'd10);
                    end
                end
                UPD: begin
                    if (round == 4'd10) busy  <= 1'b0;
                    else                round <= round + 4'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_key_schedule_seq.sv
// Directed bench for key_schedule_seq against FIPS-197 and all-zero key vectors.

module tb_key_schedule_seq;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic         busy, rk_valid, done;
    logic [3:0]   rk_round;
    logic [127:0] rk_out;

    int total = 0;
    int bad = 0;

    logic [127:0] fips_key;
    logic [127:0] fips_rk [11];

    int           npulse;
    int           done_cyc;
    int           pulse_round [16];
    logic [127:0] pulse_key [16];
    int           pulse_cyc [16];
    logic         busy_log [128];

    key_schedule_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_round (rk_round),
        .rk_out   (rk_out),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Start is sampled on the returned posedge (cycle 0).
    task automatic start_run(input logic [127:0] key);
        @(negedge clk);
        key_in = key;
        start  = 1'b1;
        @(posedge clk);
    endtask

    // Sample n cycles at negedges; cycle k is the interval after edge k-1.
    task automatic collect(input int n, input bit hold);
        npulse   = 0;
        done_cyc = -1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (k < 128) busy_log[k] = busy;
            if (rk_valid) begin
                if (npulse < 16) begin
                    pulse_round[npulse] = int'(rk_round);
                    pulse_key[npulse]   = rk_out;
                    pulse_cyc[npulse]   = k;
                end
                npulse++;
            end
            if (done) done_cyc = k;
            start = hold;
            if (hold) key_in = ~key_in;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (busy !== 1'b0 || rk_valid !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_flags busy=%b rk_valid=%b done=%b required 000", busy, rk_valid, done);
        end
        total++;
        if (rk_round !== 4'd0 || rk_out !== 128'd0) begin
            bad++;
            $display("[TB] FAIL reset_data rk_round=%0d rk_out=%h required 0/0", rk_round, rk_out);
        end
    endtask

    task automatic test_fips();
        start_run(fips_key);
        collect(53, 1'b0);
        total++;
        if (npulse !== 11) begin
            bad++;
            $display("[TB] FAIL fips_pulses got=%0d required=11", npulse);
        end
        for (int r = 0; r < 11 && r < npulse; r++) begin
            total++;
            if (pulse_key[r] !== fips_rk[r] || pulse_round[r] !== r) begin
                bad++;
                $display("[TB] FAIL fips_round%0d key=%h round=%0d required %h/%0d",
                         r, pulse_key[r], pulse_round[r], fips_rk[r], r);
            end
            total++;
            if (pulse_cyc[r] !== 1 + 5 * r) begin
                bad++;
                $display("[TB] FAIL fips_cycle%0d got=%0d required=%0d", r, pulse_cyc[r], 1 + 5 * r);
            end
        end
        total++;
        if (done_cyc !== 51) begin
            bad++;
            $display("[TB] FAIL fips_done_cycle got=%0d required=51", done_cyc);
        end
        total++;
        if (busy_log[1] !== 1'b1 || busy_log[51] !== 1'b1 || busy_log[52] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL fips_busy c1=%b c51=%b c52=%b required 1 1 0",
                     busy_log[1], busy_log[51], busy_log[52]);
        end
    endtask

    task automatic test_zero_key();
        start_run(128'd0);
        collect(53, 1'b0);
        total++;
        if (npulse !== 11) begin
            bad++;
            $display("[TB] FAIL zero_pulses got=%0d required=11", npulse);
        end
        total++;
        if (npulse > 1 && pulse_key[1] !== 128'h62636363626363636263636362636363) begin
            bad++;
            $display("[TB] FAIL zero_round1 got=%h required=62636363626363636263636362636363", pulse_key[1]);
        end
        for (int r = 0; r < 11 && r < npulse; r++) begin
            total++;
            if (pulse_round[r] !== r) begin
                bad++;
                $display("[TB] FAIL zero_order idx=%0d got=%0d required=%0d", r, pulse_round[r], r);
            end
        end
    endtask

    task automatic test_held_start();
        start_run(fips_key);
        collect(52, 1'b1);
        start = 1'b0;
        total++;
        if (npulse !== 11) begin
            bad++;
            $display("[TB] FAIL held_pulses got=%0d required=11", npulse);
        end
        for (int r = 0; r < 11 && r < npulse; r++) begin
            total++;
            if (pulse_key[r] !== fips_rk[r]) begin
                bad++;
                $display("[TB] FAIL held_round%0d got=%h required=%h", r, pulse_key[r], fips_rk[r]);
            end
        end
        total++;
        if (busy_log[52] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL held_busy52 got=%b required=0", busy_log[52]);
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        start_run(fips_key);
        collect(20, 1'b0);
        total++;
        if (npulse !== 4) begin
            bad++;
            $display("[TB] FAIL mid_prepulses got=%0d required=4", npulse);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++;
        if (busy !== 1'b0 || rk_valid !== 1'b0 || done !== 1'b0 || rk_round !== 4'd0 || rk_out !== 128'd0) begin
            bad++;
            $display("[TB] FAIL mid_reset busy=%b valid=%b done=%b round=%0d out=%h required all 0",
                     busy, rk_valid, done, rk_round, rk_out);
        end
        collect(60, 1'b0);
        total++;
        if (npulse !== 0) begin
            bad++;
            $display("[TB] FAIL mid_after_pulses got=%0d required=0", npulse);
        end
        start_run(fips_key);
        collect(53, 1'b0);
        total++;
        if (npulse !== 11 || pulse_key[10] !== fips_rk[10] || done_cyc !== 51) begin
            bad++;
            $display("[TB] FAIL mid_rerun pulses=%0d rk10=%h done_cyc=%0d required 11/%h/51",
                     npulse, pulse_key[10], done_cyc, fips_rk[10]);
        end
    endtask

    task automatic test_back_to_back();
        start_run(fips_key);
        collect(51, 1'b0);
        total++;
        if (done_cyc !== 51) begin
            bad++;
            $display("[TB] FAIL b2b_done got=%0d required=51", done_cyc);
        end
        start  = 1'b1;
        key_in = 128'd0;
        @(negedge clk);
        total++;
        if (rk_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_ignored rk_valid=%b busy=%b required 0 0", rk_valid, busy);
        end
        @(negedge clk);
        start = 1'b0;
        total++;
        if (rk_valid !== 1'b1 || rk_round !== 4'd0 || rk_out !== 128'd0 || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_restart valid=%b round=%0d out=%h busy=%b required 1/0/0/1",
                     rk_valid, rk_round, rk_out, busy);
        end
        do_reset();
    endtask

    initial begin
        fips_key   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        test_reset();
        test_fips();
        test_zero_key();
        test_held_start();
        test_reset_mid();
        test_back_to_back();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
